// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-SRAM IF/LS arbiter.
// Owner tags, arbiter states and the word-offset constant.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    typedef enum logic {
        LS_PRIO  = 1'b0,
        IF_FORCE = 1'b1
    } arb_state_e;

    localparam int WORD_OFFSET_W = 2;

    // Response tag: who owns the return slot, and whether it was a store.
    typedef struct packed {
        owner_e owner;
        logic   store;
    } tag_t;

endpackage

// File: rtl/mem_arb_if.sv
// Requester (IF/LS) and SRAM bus bundle for mem_arbiter.
// slave = arbiter side, master = core/SRAM side.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) ();

    logic                        if_req;
    logic [ADDR_W-1:0]           if_addr;
    logic                        if_gnt;
    logic                        if_rvalid;
    logic [DATA_W-1:0]           if_rdata;

    logic                        ls_req;
    logic                        ls_we;
    logic [3:0]                  ls_wstrb;
    logic [ADDR_W-1:0]           ls_addr;
    logic [DATA_W-1:0]           ls_wdata;
    logic                        ls_gnt;
    logic                        ls_rvalid;
    logic [DATA_W-1:0]           ls_rdata;

    logic                        sram_ce;
    logic [3:0]                  sram_we;
    logic [ADDR_W-WORD_OFFSET_W-1:0] sram_addr;
    logic [DATA_W-1:0]           sram_wdata;
    logic [DATA_W-1:0]           sram_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_wstrb, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output sram_ce, sram_we, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_wstrb, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  sram_ce, sram_we, sram_addr, sram_wdata,
        output sram_rdata
    );

endinterface

// File: rtl/mem_arb_tag_pipe.sv
// SRAM_LAT-deep shift register of response tags with synchronous flush.
// tag_out is the tag whose SRAM data is on sram_rdata this cycle.
module mem_arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int SRAM_LAT = 1
) (
    input  logic clk,
    input  logic flush,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage_q [SRAM_LAT];

    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < SRAM_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < SRAM_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[SRAM_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// IF/LS arbiter for one single-port unified SRAM with fetch starvation guard.
// Optional MEM_ARB_DIFFTEST_EN adds registered store-trace outputs dt_*.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int SRAM_LAT   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_arb_if.slave          bus
`ifdef MEM_ARB_DIFFTEST_EN
    ,
    output logic [3:0]        dt_wen,
    output logic [ADDR_W-1:0] dt_waddr,
    output logic [DATA_W-1:0] dt_wdata
`endif
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       gnt_if;
    logic       gnt_ls;
    logic       st_gnt;
    tag_t       tag_in;
    tag_t       tag_out;
    logic       if_hit;
    logic       ls_hit;
    logic       unused_addr_lsb;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        gnt_if  = 1'b0;
        gnt_ls  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                LS_PRIO: begin
                    if (bus.ls_req) begin
                        gnt_ls = 1'b1;
                        // IF denied: count it, or force IF next cycle
                        if (bus.if_req) begin
                            if (cnt_q == 4'(STARVE_MAX - 1)) begin
                                state_d = IF_FORCE;
                            end else begin
                                cnt_d = cnt_q + 4'd1;
                            end
                        end
                    end else if (bus.if_req) begin
                        gnt_if = 1'b1;
                    end
                end
                IF_FORCE: begin
                    state_d = LS_PRIO;
                    if (bus.if_req) begin
                        gnt_if = 1'b1;
                    end else if (bus.ls_req) begin
                        gnt_ls = 1'b1;
                    end
                end
                default: state_d = LS_PRIO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LS_PRIO;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign st_gnt = gnt_ls & bus.ls_we;

    assign bus.if_gnt     = gnt_if;
    assign bus.ls_gnt     = gnt_ls;
    assign bus.sram_ce    = gnt_if | gnt_ls;
    assign bus.sram_we    = st_gnt ? bus.ls_wstrb : 4'b0000;
    assign bus.sram_wdata = bus.ls_wdata;
    assign bus.sram_addr  = gnt_if
        ? bus.if_addr[ADDR_W-1:WORD_OFFSET_W]
        : bus.ls_addr[ADDR_W-1:WORD_OFFSET_W];

    assign unused_addr_lsb = ^{bus.if_addr[WORD_OFFSET_W-1:0],
                               bus.ls_addr[WORD_OFFSET_W-1:0]};

    always_comb begin
        tag_in.owner = OWN_NONE;
        tag_in.store = st_gnt;
        if (gnt_if) begin
            tag_in.owner = OWN_IF;
        end else if (gnt_ls) begin
            tag_in.owner = OWN_LS;
        end
    end

    mem_arb_tag_pipe #(
        .SRAM_LAT (SRAM_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .flush   (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Responses are masked while rst is held so nothing leaks mid-flush.
    assign if_hit = !rst && (tag_out.owner == OWN_IF);
    assign ls_hit = !rst && (tag_out.owner == OWN_LS);

    assign bus.if_rvalid = if_hit;
    assign bus.ls_rvalid = ls_hit;
    assign bus.if_rdata  = if_hit ? bus.sram_rdata : '0;
    assign bus.ls_rdata  = (ls_hit && !tag_out.store)
        ? bus.sram_rdata : '0;

`ifdef MEM_ARB_DIFFTEST_EN
    logic [3:0]        dt_wen_q;
    logic [ADDR_W-1:0] dt_waddr_q;
    logic [DATA_W-1:0] dt_wdata_q;

    always_ff @(posedge clk) begin
        if (rst || !st_gnt) begin
            dt_wen_q   <= '0;
            dt_waddr_q <= '0;
            dt_wdata_q <= '0;
        end else begin
            dt_wen_q   <= bus.ls_wstrb;
            dt_waddr_q <= {bus.ls_addr[ADDR_W-1:WORD_OFFSET_W],
                           {WORD_OFFSET_W{1'b0}}};
            dt_wdata_q <= bus.ls_wdata;
        end
    end

    assign dt_wen   = rst ? '0 : dt_wen_q;
    assign dt_waddr = rst ? '0 : dt_waddr_q;
    assign dt_wdata = rst ? '0 : dt_wdata_q;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified SRAM (64 KiB, 32-bit words) between the core's instruction-fetch (IF) port and its load/store (LS) port.
- Needed once IM and DM are merged into one physical array for the multicycle/pipelined core.
- Performs arbitration, word-address translation, and read-data return routing with a fixed SRAM read latency.
- Includes starvation protection so fetch always makes progress under load/store bursts.

Parameters:
- ADDR_W, 16, byte address width of both requester ports.
- DATA_W, 32, data width; fixed at 32, with 4 byte lanes.
- SRAM_LAT, 1, cycles from SRAM access to valid sram_rdata; legal range 1..4.
- STARVE_MAX, 4, consecutive denied IF-request cycles before IF is forced a grant; legal range 1..15.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request, held until granted
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch data
- ls_req  in  1  load/store request, held until granted
- ls_we  in  1  1 = store
- ls_wstrb  in  4  store byte enables
- ls_addr  in  ADDR_W  load/store byte address
- ls_wdata  in  DATA_W  store data
- ls_gnt  out  1  load/store accepted this cycle
- ls_rvalid  out  1  load data valid or store acknowledge
- ls_rdata  out  DATA_W  load data; 0 on store acknowledge
- sram_ce  out  1  SRAM access enable
- sram_we  out  4  SRAM byte write enables
- sram_addr  out  ADDR_W-2  SRAM word address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid SRAM_LAT cycles after access

Behaviour:
- One clock; reset is synchronous and active-high. Port names are clk and rst.
- Reset values: all gnt, rvalid, sram_ce, sram_we = 0; rdata = 0; starvation counter = 0; FSM = LS_PRIO; tag pipeline cleared.
- Grants are combinational from req and state. A request is accepted in the cycle gnt=1. Requester must hold req/addr/data stable until gnt.
- At most one grant per cycle. A new grant is allowed every cycle (fully pipelined, no bubbles).
- SRAM drive, in the grant cycle:
  - sram_ce=1
  - sram_addr = granted addr[ADDR_W-1:2]; addr[1:0] is ignored
  - sram_we = ls_wstrb if LS granted with ls_we=1, else 0
  - sram_wdata = ls_wdata
- Response: exactly SRAM_LAT cycles after a grant, the owner's rvalid pulses for 1 cycle.
  - Fetch/load: rdata = sram_rdata.
  - Store: ls_rvalid=1, ls_rdata=0.
  - Non-owner rdata is held at 0.
- Owner tags travel in a SRAM_LAT-deep shift register. Out-of-order return is impossible.
- FSM, 2 states:
  - LS_PRIO:
    - ls_req wins whenever asserted.
    - If if_req && ls_req, starve_cnt increments.
    - When starve_cnt == STARVE_MAX-1 and the increment would occur, go to IF_FORCE instead.
    - starve_cnt clears whenever IF is granted or if_req=0.
  - IF_FORCE:
    - IF wins if if_req=1. If if_req has dropped, LS may be granted.
    - Return to LS_PRIO next cycle unconditionally, with starve_cnt=0.
- Worst case: IF waits STARVE_MAX cycles, then is granted in the next.
- Only one requester: it is granted immediately in either state.
- No requests: sram_ce=0, state unchanged, starve_cnt=0.
- rst asserted mid-operation: tag pipeline is flushed, so in-flight responses do not produce rvalid. gnt is forced 0 during rst.

Optional Feature:
- Macro MEM_ARB_DIFFTEST_EN.
- Defined: adds outputs dt_wen[3:0], dt_waddr[ADDR_W-1:0], dt_wdata[DATA_W-1:0], registered one cycle after each granted store.
  - dt_wen = ls_wstrb; dt_waddr = word-aligned byte address.
  - Zero in all other cycles and during reset.
  - These feed the difftest store-checker DPI call.
- Undefined: ports and logic are absent; arbiter behaviour is identical.

Decomposition:
- Package mem_arb_pkg:
  - owner_e {OWN_NONE, OWN_IF, OWN_LS}
  - arb_state_e {LS_PRIO, IF_FORCE}
  - WORD_OFFSET_W=2
- Sub-module mem_arb_tag_pipe: SRAM_LAT-deep owner_e shift register with synchronous flush. Returns the tag at the output stage.

Test Plan:
- Fetch only, SRAM_LAT=1: if_req at addr 0x0010 → if_gnt same cycle, sram_addr=0x0004, sram_ce=1. Next cycle if_rvalid=1, if_rdata = memory word 4.
- Store then load back-to-back: store ls_wstrb=4'b0011, wdata 0xDEADBEEF to 0x0100, then load 0x0100 → sram_we=0011 then 0000. Two ls_rvalid pulses. Second ls_rdata = 0x0000BEEF over prior zeros.
- Contention, STARVE_MAX=4: if_req and ls_req both held high → ls_gnt cycles 1–4, if_gnt cycle 5, LS resumes cycle 6. Pattern repeats every 5 cycles.
- SRAM_LAT=3, alternating IF/LS grants every cycle → rvalids return in grant order exactly 3 cycles later, with no cross-routing of rdata.
- rst pulsed 1 cycle after a load grant (SRAM_LAT=2) → no ls_rvalid. All outputs 0 during rst. FSM returns to LS_PRIO.
- MEM_ARB_DIFFTEST_EN: store 0x12345678, strobe 1111, to 0x0202 → next cycle dt_wen=1111, dt_waddr=0x0200, dt_wdata=0x12345678. Zero otherwise.
